// File: rtl/ps2_key_sequencer_if.sv
// Event stream from the PS/2 key sequencer to its consumer.
// The producer drives the head event; the consumer answers with ev_ready to pop it.
interface ps2_key_sequencer_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_extended;
    logic       ev_release;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_extended,
        output ev_release,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_extended,
        input  ev_release,
        output ev_ready
    );
endinterface

// File: rtl/ps2_key_sequencer.sv
// Turns raw PS/2 scan bytes into make/break events with E0/F0 prefixes folded in,
// queued in a small first-word-fall-through FIFO. All state moves on the falling clock edge.
//
// state  | meaning
// IDLE   | waiting for the receiver to raise irq
// ACK    | byte captured, clear_keycode held high until irq drops
// DECODE | one cycle: update prefix flags or push an event
module ps2_key_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        irq,
    input  logic [7:0]                  keycode,
    output logic                        clear_keycode,
    ps2_key_sequencer_if.master         ev,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        overflow_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        DECODE
    } state_t;

    state_t           state;
    logic [7:0]       byte_reg;
    logic             ext_flag;
    logic             rel_flag;

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             is_data;
    logic             pop;
    logic             push_ok;
    logic             push_drop;
    logic             fifo_full;

    always_comb begin
        is_data   = 1'b0;
        if (state == DECODE) begin
            is_data = (byte_reg != 8'hE0) && (byte_reg != 8'hF0) &&
                      (byte_reg != 8'h00) && (byte_reg != 8'hFF);
        end
        fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
        pop       = (fifo_count != '0) && ev.ev_ready;
        // A full FIFO can still take the byte if the head leaves on the same edge.
        push_ok   = is_data && (!fifo_full || pop);
        push_drop = is_data && !push_ok;
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            byte_reg      <= 8'h00;
            ext_flag      <= 1'b0;
            rel_flag      <= 1'b0;
            clear_keycode <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (irq) begin
                        byte_reg      <= keycode;
                        clear_keycode <= 1'b1;
                        state         <= ACK;
                    end
                end
                ACK: begin
                    if (!irq) begin
                        clear_keycode <= 1'b0;
                        state         <= DECODE;
                    end
                end
                DECODE: begin
                    state <= IDLE;
                    case (byte_reg)
                        8'hE0:   ext_flag <= 1'b1;
                        8'hF0:   rel_flag <= 1'b1;
                        default: begin
                            // Error bytes and real codes both end the prefix sequence.
                            ext_flag <= 1'b0;
                            rel_flag <= 1'b0;
                        end
                    endcase
                end
                default: begin
                    clear_keycode <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {ext_flag, rel_flag, byte_reg};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        ev.ev_valid    = (fifo_count != '0);
        ev.ev_code     = 8'h00;
        ev.ev_extended = 1'b0;
        ev.ev_release  = 1'b0;
        if (fifo_count != '0) begin
            {ev.ev_extended, ev.ev_release, ev.ev_code} = mem[rd_ptr];
        end
    end

endmodule
